// File: rtl/prefix_addsub_pipe_v4_if.sv
// prefix_addsub_pipe_v4_if: operand/result valid-ready bundle for the prefix add/sub pipe
interface prefix_addsub_pipe_v4_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_sub;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;
  logic             out_zero;
  modport master (
    output in_valid, in_a, in_b, in_sub, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
  );
  modport slave (
    input  in_valid, in_a, in_b, in_sub, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
  );
endinterface

// File: rtl/prefix_addsub_pipe_v4.sv
// prefix_addsub_pipe_v4: pipelined valency-4 Kogge-Stone adder/subtractor with valid/ready flow control
module prefix_addsub_pipe_v4 #(
  parameter int WIDTH = 16
) (
  input logic                      clk,
  input logic                      rst_n,
  prefix_addsub_pipe_v4_if.slave   bus
);
  localparam int LEVELS = (WIDTH == 4) ? 1 : (WIDTH == 16) ? 2 : 3;
  localparam logic [WIDTH-1:0] ONES = '1;
  localparam logic [LEVELS:0] V_ONES = '1;
  if (WIDTH != 4 && WIDTH != 16 && WIDTH != 64) begin : g_bad_width
    $error("prefix_addsub_pipe_v4: WIDTH must be 4, 16 or 64");
  end
  logic [WIDTH-1:0] b_eff, g_in, p_in;
  logic             c0_in;
  logic [WIDTH-1:0] gg_q [LEVELS];
  logic [WIDTH-1:0] pp_q [LEVELS];
  logic [WIDTH-1:0] pb_q [LEVELS];
  logic [LEVELS-1:0] c0_q;
  logic [WIDTH-1:0] gg_d [LEVELS];
  logic [WIDTH-1:0] pp_d [LEVELS];
  logic [WIDTH-1:0] gs [4];
  logic [WIDTH-1:0] ps [4];
  logic [LEVELS:0]  v_q, free;
  logic [WIDTH-1:0] sum_d, sum_q;
  logic             cout_d, ovf_d, cout_q, ovf_q, zero_q;
  always_comb begin
    b_eff = bus.in_sub ? ~bus.in_b : bus.in_b;
    c0_in = bus.in_sub | bus.in_cin;
    p_in = bus.in_a ^ b_eff;
    g_in = bus.in_a & b_eff;
    g_in[0] = g_in[0] | (p_in[0] & c0_in);
    gs = '{default: '0};
    ps = '{default: '0};
    gg_d = '{default: '0};
    pp_d = '{default: '0};
    for (int k = 0; k < LEVELS; k++) begin
      for (int j = 0; j < 4; j++) begin
        gs[j] = (gg_q[k] << (j * 4**k)) | ({WIDTH{c0_q[k]}} & ~(ONES << (j * 4**k)));
        ps[j] = pp_q[k] << (j * 4**k);
      end
      gg_d[k] = gs[0] | ps[0] & (gs[1] | ps[1] & (gs[2] | ps[2] & gs[3]));
      pp_d[k] = ps[0] & ps[1] & ps[2] & ps[3];
    end
    sum_d = pb_q[LEVELS-1] ^ {gg_d[LEVELS-1][WIDTH-2:0], c0_q[LEVELS-1]};
    cout_d = gg_d[LEVELS-1][WIDTH-1];
    ovf_d = gg_d[LEVELS-1][WIDTH-1] ^ gg_d[LEVELS-1][WIDTH-2];
    free = '0;
    for (int s = 0; s <= LEVELS; s++)
      free[s] = bus.out_ready | ((v_q >> s) != (V_ONES >> s));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      sum_q <= '0;
      cout_q <= 1'b0;
      ovf_q <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      if (free[0]) v_q[0] <= bus.in_valid;
      for (int s = 1; s <= LEVELS; s++)
        if (free[s]) v_q[s] <= v_q[s-1];
      if (free[LEVELS]) begin
        sum_q <= sum_d;
        cout_q <= cout_d;
        ovf_q <= ovf_d;
        zero_q <= ~|sum_d;
      end
    end
  end
  // Prefix datapath carries no reset; only the valid bits qualify it
  always_ff @(posedge clk) begin
    if (free[0]) begin
      gg_q[0] <= g_in;
      pp_q[0] <= p_in;
      pb_q[0] <= p_in;
      c0_q[0] <= c0_in;
    end
    for (int s = 1; s < LEVELS; s++)
      if (free[s]) begin
        gg_q[s] <= gg_d[s-1];
        pp_q[s] <= pp_d[s-1];
        pb_q[s] <= pb_q[s-1];
        c0_q[s] <= c0_q[s-1];
      end
  end
  assign bus.in_ready = free[0];
  assign bus.out_valid = v_q[LEVELS];
  assign bus.out_sum = sum_q;
  assign bus.out_cout = cout_q;
  assign bus.out_ovf = ovf_q;
  assign bus.out_zero = zero_q;
endmodule

// File: tb/tb_prefix_addsub_pipe_v4.sv
// tb_prefix_addsub_pipe_v4: scoreboard bench comparing the pipe against signed/unsigned arithmetic
module tb_prefix_addsub_pipe_v4;
  localparam int W = 16;
  typedef struct packed {logic [W-1:0] s; logic c; logic o; logic z;} res_t;
  logic clk = 0;
  logic rst_n = 0;
  always #5 clk = ~clk;
  prefix_addsub_pipe_v4_if #(.WIDTH(W)) bus();
  prefix_addsub_pipe_v4 #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  res_t q[$];
  res_t last_res, held;
  int n_vec = 0, n_err = 0, n_out = 0;
  bit rand_rdy = 0, was_stall = 0;
  function automatic res_t model(logic [W-1:0] a, logic [W-1:0] b, logic sub, logic cin);
    res_t r;
    logic [W-1:0] bb = sub ? ~b : b;
    logic [W:0] full = {1'b0, a} + {1'b0, bb} + {16'd0, (sub | cin)};
    longint sr = sub ? longint'($signed(a)) - longint'($signed(b))
                     : longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
    r.s = full[W-1:0];
    r.c = full[W];
    r.o = (sr > 32767) || (sr < -32768);
    r.z = (r.s == 0);
    return r;
  endfunction
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  function automatic res_t cur();
    return {bus.out_sum, bus.out_cout, bus.out_ovf, bus.out_zero};
  endfunction
  always @(negedge clk) begin
    if (!rst_n) was_stall = 0;
    else begin
      if (was_stall) chk("stall_hold", {bus.out_valid, cur()}, {1'b1, held});
      was_stall = bus.out_valid && !bus.out_ready;
      held = cur();
      if (bus.out_valid && bus.out_ready) begin
        n_out++;
        last_res = cur();
        if (q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_beat: got %0h want none", cur());
        end else chk("result", cur(), q.pop_front());
      end
      if (bus.in_valid && bus.in_ready) q.push_back(model(bus.in_a, bus.in_b, bus.in_sub, bus.in_cin));
    end
  end
  always @(posedge clk) if (rand_rdy) begin
    #1 bus.out_ready = 1'($urandom_range(0, 1));
  end
  task automatic send(logic [W-1:0] a, logic [W-1:0] b, logic sub, logic cin, output int tries);
    bit acc = 0;
    bus.in_valid = 1; bus.in_a = a; bus.in_b = b; bus.in_sub = sub; bus.in_cin = cin;
    tries = 0;
    while (!acc && tries < 500) begin
      @(negedge clk); acc = bus.in_ready;
      @(posedge clk); #1; tries++;
    end
    if (!acc) chk("accept_timeout", 0, 1);
  endtask
  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 1000) begin @(posedge clk); t++; end
    chk("drain_left", q.size(), 0);
    @(posedge clk); #1;
  endtask
  task automatic dir(string nm, logic [W-1:0] a, logic [W-1:0] b, logic sub, logic cin, res_t exp);
    int t;
    send(a, b, sub, cin, t);
    bus.in_valid = 0;
    drain();
    chk(nm, last_res, exp);
  endtask
  initial begin
    int t, base;
    bus.in_valid = 0; bus.in_a = 0; bus.in_b = 0; bus.in_sub = 0; bus.in_cin = 0; bus.out_ready = 1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_outputs", cur(), 0);
    chk("rst_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    send(16'h1234, 16'h0FCD, 0, 1, t);
    bus.in_valid = 0;
    @(negedge clk); chk("lat_e1", bus.out_valid, 0);
    @(negedge clk); chk("lat_e2", bus.out_valid, 0);
    @(negedge clk); chk("lat_e3", bus.out_valid, 1);
    chk("t1_sum", cur(), {16'h2202, 1'b0, 1'b0, 1'b0});
    @(negedge clk); chk("one_cycle", bus.out_valid, 0);
    @(posedge clk); #1;
    dir("sub_borrow", 16'h0005, 16'h0007, 1, 0, {16'hFFFE, 1'b0, 1'b0, 1'b0});
    dir("sub_ovf", 16'h8000, 16'h0001, 1, 1, {16'h7FFF, 1'b1, 1'b1, 1'b0});
    dir("sub_zero", 16'hBEEF, 16'hBEEF, 1, 0, {16'h0000, 1'b1, 1'b0, 1'b1});
    dir("ripple", 16'hFFFF, 16'h0000, 0, 1, {16'h0000, 1'b1, 1'b0, 1'b1});
    dir("add_ovf", 16'h7FFF, 16'h0001, 0, 0, {16'h8000, 1'b0, 1'b1, 1'b0});
    base = n_out;
    for (int i = 0; i < 100; i++) begin
      send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), t);
      chk("stream_tries", t, 1);
    end
    bus.in_valid = 0;
    drain();
    chk("stream_count", n_out - base, 100);
    bus.out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), t);
      chk("fill_tries", t, 1);
    end
    bus.in_valid = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("full_in_ready", bus.in_ready, 0);
      chk("full_out_valid", bus.out_valid, 1);
    end
    @(posedge clk); #1;
    base = n_out;
    rand_rdy = 1;
    for (int i = 0; i < 1000; i++) begin
      send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), t);
      if ($urandom_range(0, 3) == 0) begin bus.in_valid = 0; @(posedge clk); #1; end
    end
    bus.in_valid = 0;
    rand_rdy = 0;
    @(posedge clk); #2 bus.out_ready = 1;
    drain();
    chk("bp_count", n_out - base, 1003);
    bus.out_ready = 0;
    for (int i = 0; i < 3; i++) send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), t);
    bus.in_valid = 0;
    #3 rst_n = 0;
    q.delete();
    #1;
    chk("arst_out_valid", bus.out_valid, 0);
    chk("arst_outputs", cur(), 0);
    @(posedge clk); #1 rst_n = 1;
    bus.out_ready = 1;
    repeat (5) begin @(negedge clk); chk("post_rst_quiet", bus.out_valid, 0); end
    @(posedge clk); #1;
    dir("post_rst_beat", 16'h00FF, 16'h0F01, 0, 0, {16'h1000, 1'b0, 1'b0, 1'b0});
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule
